// File: rtl/datapath_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_param_if
//  Description : Control/data bundle between the instruction-decode FSM,
//                memory/PC logic and the parametrised datapath.
//                master : decode/memory side (drives strobes, immediates,
//                         mdata, PC; observes C and Z_out)
//                slave  : datapath side
//  Parameters  : W (data width), NREG (register count), PCW (PC width)
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_param_if #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int PCW  = 8
);
   localparam int RW = $clog2(NREG);

   logic [RW-1:0]  readnum_a;
   logic [RW-1:0]  readnum_b;
   logic [RW-1:0]  writenum;
   logic           write;
   logic [1:0]     vsel;
   logic           loada;
   logic           loadb;
   logic           asel;
   logic           bsel;
   logic [1:0]     shift;
   logic [1:0]     ALUop;
   logic           loadc;
   logic           loads;
   logic [W-1:0]   sximm8;
   logic [W-1:0]   sximm5;
   logic [W-1:0]   mdata;
   logic [PCW-1:0] PC;
   logic [W-1:0]   C;
   logic [2:0]     Z_out;

   modport master (
      output readnum_a, readnum_b, writenum, write, vsel,
      output loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
      output sximm8, sximm5, mdata, PC,
      input  C, Z_out
   );

   modport slave (
      input  readnum_a, readnum_b, writenum, write, vsel,
      input  loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
      input  sximm8, sximm5, mdata, PC,
      output C, Z_out
   );
endinterface
`default_nettype wire

// File: rtl/datapath_param.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_param
//  Description : Parametrised datapath: NREG x W register file with two
//                combinational read ports, A/B operand registers, B-side
//                shifter (none/LSL1/LSR1/ASR1), 4-op ALU, result register C
//                and 3-bit status register Z_out {zero, negative, overflow}.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high, clears all state
//                bus    - datapath_param_if.slave (strobes, selects,
//                         immediates, mdata, PC in; C, Z_out out)
//  Options     : DATAPATH_BYPASS_EN - when defined, a read port whose index
//                matches writenum during a write returns data_in in the
//                same cycle (write-through forwarding).
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_param #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int PCW  = 8
) (
   input  logic            clk,
   input  logic            reset,
   datapath_param_if.slave bus
);

   // ------------------------------------------------------------------------
   // Storage and internal nets
   // ------------------------------------------------------------------------
   logic [W-1:0] regs [NREG];
   logic [W-1:0] data_in;
   logic [W-1:0] pc_ext;
   logic [W-1:0] read_a;
   logic [W-1:0] read_b;
   logic [W-1:0] reg_a;
   logic [W-1:0] reg_b;
   logic [W-1:0] reg_c;
   logic [2:0]   reg_z;
   logic [W-1:0] b_shifted;
   logic [W-1:0] ain;
   logic [W-1:0] bin;
   logic [W-1:0] alu_out;
   logic         alu_ovf;
   logic [2:0]   alu_flags;

   // ------------------------------------------------------------------------
   // Writeback source select
   // ------------------------------------------------------------------------
   // PC is narrower than the datapath; zero-extend without a replication
   // that would collapse to zero width when PCW == W.
   always_comb begin
      pc_ext            = '0;
      pc_ext[PCW-1:0]   = bus.PC;
   end

   // vsel=00 writes the registered C, not the live ALU output.
   always_comb begin
      data_in = reg_c;
      case (bus.vsel)
         2'b00:   data_in = reg_c;
         2'b01:   data_in = pc_ext;
         2'b10:   data_in = bus.sximm8;
         default: data_in = bus.mdata;
      endcase
   end

   // ------------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.write) begin
         regs[bus.writenum] <= data_in;
      end
   end

   // Two independent combinational read ports; equal indices are legal.
`ifdef DATAPATH_BYPASS_EN
   assign read_a = (bus.write && (bus.writenum == bus.readnum_a)) ? data_in
                                                                  : regs[bus.readnum_a];
   assign read_b = (bus.write && (bus.writenum == bus.readnum_b)) ? data_in
                                                                  : regs[bus.readnum_b];
`else
   // Without forwarding a same-cycle write is only visible next cycle.
   assign read_a = regs[bus.readnum_a];
   assign read_b = regs[bus.readnum_b];
`endif

   // ------------------------------------------------------------------------
   // Operand registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_a <= '0;
         reg_b <= '0;
      end else begin
         if (bus.loada) begin
            reg_a <= read_a;
         end
         if (bus.loadb) begin
            reg_b <= read_b;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shifter (B only) and ALU operand muxes
   // ------------------------------------------------------------------------
   always_comb begin
      b_shifted = reg_b;
      case (bus.shift)
         2'b00:   b_shifted = reg_b;
         2'b01:   b_shifted = {reg_b[W-2:0], 1'b0};
         2'b10:   b_shifted = {1'b0, reg_b[W-1:1]};
         default: b_shifted = {reg_b[W-1], reg_b[W-1:1]};
      endcase
   end

   // An immediate on the B side bypasses the shifter entirely.
   assign ain = bus.asel ? '0         : reg_a;
   assign bin = bus.bsel ? bus.sximm5 : b_shifted;

   // ------------------------------------------------------------------------
   // ALU (modulo 2^W) with signed-overflow detection
   // ------------------------------------------------------------------------
   always_comb begin
      alu_out = '0;
      alu_ovf = 1'b0;
      case (bus.ALUop)
         2'b00: begin
            alu_out = ain + bin;
            // Like-signed operands producing an opposite-signed sum.
            alu_ovf = (ain[W-1] == bin[W-1]) && (alu_out[W-1] != ain[W-1]);
         end
         2'b01: begin
            alu_out = ain - bin;
            // Unlike-signed operands where the result leaves Ain's sign.
            alu_ovf = (ain[W-1] != bin[W-1]) && (alu_out[W-1] != ain[W-1]);
         end
         2'b10: begin
            alu_out = ain & bin;
         end
         default: begin
            alu_out = ~bin;
         end
      endcase
   end

   assign alu_flags = {(alu_out == '0), alu_out[W-1], alu_ovf};

   // ------------------------------------------------------------------------
   // Result and status registers (independent strobes)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_c <= '0;
         reg_z <= '0;
      end else begin
         if (bus.loadc) begin
            reg_c <= alu_out;
         end
         if (bus.loads) begin
            reg_z <= alu_flags;
         end
      end
   end

   assign bus.C     = reg_c;
   assign bus.Z_out = reg_z;

endmodule
`default_nettype wire

// File: tb/tb_datapath_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_param
//  Description : Self-checking bench for datapath_param. Directed scenarios
//                on a W=16/NREG=8 instance and a W=8/NREG=16 instance, then
//                randomized traffic against an arithmetic reference model.
//                Honors DATAPATH_BYPASS_EN for forwarding expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   datapath_param_if #(.W(16), .NREG(8),  .PCW(8)) bus16 ();
   datapath_param_if #(.W(8),  .NREG(16), .PCW(8)) bus8 ();

   datapath_param #(.W(16), .NREG(8), .PCW(8)) dut16 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus16.slave)
   );

   datapath_param #(.W(8), .NREG(16), .PCW(8)) dut8 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus8.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

`ifdef DATAPATH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Stimulus helpers (no checking inside)
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle16();
      bus16.readnum_a = '0; bus16.readnum_b = '0; bus16.writenum = '0;
      bus16.write = 0; bus16.vsel = 2'b00; bus16.loada = 0; bus16.loadb = 0;
      bus16.asel = 0; bus16.bsel = 0; bus16.shift = 2'b00; bus16.ALUop = 2'b00;
      bus16.loadc = 0; bus16.loads = 0;
      bus16.sximm8 = '0; bus16.sximm5 = '0; bus16.mdata = '0; bus16.PC = '0;
   endtask

   task automatic idle8();
      bus8.readnum_a = '0; bus8.readnum_b = '0; bus8.writenum = '0;
      bus8.write = 0; bus8.vsel = 2'b00; bus8.loada = 0; bus8.loadb = 0;
      bus8.asel = 0; bus8.bsel = 0; bus8.shift = 2'b00; bus8.ALUop = 2'b00;
      bus8.loadc = 0; bus8.loads = 0;
      bus8.sximm8 = '0; bus8.sximm5 = '0; bus8.mdata = '0; bus8.PC = '0;
   endtask

   task automatic wr16(input int idx, input logic [15:0] val);
      bus16.writenum = 3'(idx); bus16.vsel = 2'b11; bus16.mdata = val;
      bus16.write = 1; step(); bus16.write = 0;
   endtask

   task automatic wr8(input int idx, input logic [7:0] val);
      bus8.writenum = 4'(idx); bus8.vsel = 2'b11; bus8.mdata = val;
      bus8.write = 1; step(); bus8.write = 0;
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1;
      idle16(); idle8();
      step(); step();
      n_checks++;
      if (bus16.C !== 16'h0) begin
         n_fail++; $display("FAIL reset_c: got %h expected 0000", bus16.C);
      end
      n_checks++;
      if (bus16.Z_out !== 3'b000) begin
         n_fail++; $display("FAIL reset_z: got %b expected 000", bus16.Z_out);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (dut16.regs[i] !== 16'h0) begin
            n_fail++; $display("FAIL reset_r%0d: got %h expected 0000", i, dut16.regs[i]);
         end
      end
      rst = 0;
      step();
   endtask

   task automatic test_sub();
      idle16();
      wr16(3, 16'd169);
      wr16(4, 16'd100);
      bus16.readnum_a = 3; bus16.readnum_b = 4; bus16.loada = 1; bus16.loadb = 1;
      step();
      bus16.loada = 0; bus16.loadb = 0;
      bus16.shift = 2'b00; bus16.ALUop = 2'b01; bus16.loadc = 1;
      step();
      bus16.loadc = 0;
      n_checks++;
      if (bus16.C !== 16'd69) begin
         n_fail++; $display("FAIL sub_c: got %h expected 0045", bus16.C);
      end
      bus16.vsel = 2'b00; bus16.writenum = 5; bus16.write = 1;
      step();
      bus16.write = 0;
      n_checks++;
      if (dut16.regs[5] !== 16'd69) begin
         n_fail++; $display("FAIL sub_wb_r5: got %h expected 0045", dut16.regs[5]);
      end
   endtask

   task automatic test_shift_add();
      idle16();
      wr16(0, 16'd7);
      wr16(1, 16'd2);
      bus16.readnum_b = 0; bus16.readnum_a = 1; bus16.loada = 1; bus16.loadb = 1;
      step();
      bus16.loada = 0; bus16.loadb = 0;
      bus16.shift = 2'b01; bus16.ALUop = 2'b00; bus16.loadc = 1;
      step();
      bus16.loadc = 0;
      n_checks++;
      if (bus16.C !== 16'h0010) begin
         n_fail++; $display("FAIL lsl_add_c: got %h expected 0010", bus16.C);
      end
      bus16.vsel = 2'b00; bus16.writenum = 2; bus16.write = 1;
      step();
      bus16.write = 0;
      n_checks++;
      if (dut16.regs[2] !== 16'h0010) begin
         n_fail++; $display("FAIL lsl_add_r2: got %h expected 0010", dut16.regs[2]);
      end
   endtask

   task automatic test_flags();
      idle16();
      wr16(1, 16'h7FFF);
      wr16(2, 16'h0001);
      bus16.readnum_a = 1; bus16.readnum_b = 2; bus16.loada = 1; bus16.loadb = 1;
      step();
      bus16.loada = 0; bus16.loadb = 0;
      bus16.ALUop = 2'b00; bus16.loadc = 1; bus16.loads = 1;
      step();
      n_checks++;
      if (bus16.C !== 16'h8000) begin
         n_fail++; $display("FAIL add_ovf_c: got %h expected 8000", bus16.C);
      end
      n_checks++;
      if (bus16.Z_out !== 3'b011) begin
         n_fail++; $display("FAIL add_ovf_z: got %b expected 011", bus16.Z_out);
      end
      // R6/R7 untouched since reset -> both zero
      bus16.loadc = 0; bus16.loads = 0;
      bus16.readnum_a = 6; bus16.readnum_b = 7; bus16.loada = 1; bus16.loadb = 1;
      step();
      bus16.loada = 0; bus16.loadb = 0;
      bus16.ALUop = 2'b01; bus16.loadc = 1; bus16.loads = 1;
      step();
      bus16.loadc = 0; bus16.loads = 0;
      n_checks++;
      if (bus16.Z_out !== 3'b100) begin
         n_fail++; $display("FAIL sub_zero_z: got %b expected 100", bus16.Z_out);
      end
      wr16(3, 16'h8000);
      bus16.readnum_b = 3; bus16.loadb = 1;
      step();
      bus16.loadb = 0;
      bus16.asel = 1; bus16.ALUop = 2'b00; bus16.shift = 2'b11; bus16.loadc = 1;
      step();
      n_checks++;
      if (bus16.C !== 16'hC000) begin
         n_fail++; $display("FAIL asr_c: got %h expected c000", bus16.C);
      end
      bus16.shift = 2'b10;
      step();
      n_checks++;
      if (bus16.C !== 16'h4000) begin
         n_fail++; $display("FAIL lsr_c: got %h expected 4000", bus16.C);
      end
      idle16();
   endtask

   task automatic test_vsel_and_reset();
      idle16();
      bus16.PC = 8'hAA; bus16.sximm8 = 16'h0055; bus16.mdata = 16'h0001;
      bus16.vsel = 2'b11; bus16.writenum = 1; bus16.write = 1;
      #1;
      n_checks++;
      if (dut16.data_in !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_mdata_din: got %h expected 0001", dut16.data_in);
      end
      step();
      n_checks++;
      if (dut16.regs[1] !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_mdata_r1: got %h expected 0001", dut16.regs[1]);
      end
      bus16.mdata = 16'h0077; bus16.PC = 8'h01; bus16.vsel = 2'b01; bus16.writenum = 2;
      #1;
      n_checks++;
      if (dut16.data_in !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_pc_din: got %h expected 0001", dut16.data_in);
      end
      step();
      n_checks++;
      if (dut16.regs[2] !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_pc_r2: got %h expected 0001", dut16.regs[2]);
      end
      bus16.PC = 8'h33; bus16.sximm8 = 16'h0001; bus16.vsel = 2'b10; bus16.writenum = 3;
      #1;
      n_checks++;
      if (dut16.data_in !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_imm8_din: got %h expected 0001", dut16.data_in);
      end
      step();
      bus16.write = 0;
      n_checks++;
      if (dut16.regs[3] !== 16'h0001) begin
         n_fail++; $display("FAIL vsel_imm8_r3: got %h expected 0001", dut16.regs[3]);
      end
      // Reset between edges: C=4000 and Z=100 are still held from before.
      #2;
      rst = 1;
      #1;
      n_checks++;
      if (bus16.C !== 16'h0) begin
         n_fail++; $display("FAIL async_reset_c: got %h expected 0000", bus16.C);
      end
      n_checks++;
      if (bus16.Z_out !== 3'b000) begin
         n_fail++; $display("FAIL async_reset_z: got %b expected 000", bus16.Z_out);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (dut16.regs[i] !== 16'h0) begin
            n_fail++; $display("FAIL async_reset_r%0d: got %h expected 0000", i, dut16.regs[i]);
         end
      end
      step();
      rst = 0;
      step();
   endtask

   task automatic test_w8();
      idle8();
      wr8(15, 8'h80);
      wr8(14, 8'h80);
      bus8.readnum_a = 15; bus8.readnum_b = 14; bus8.loada = 1; bus8.loadb = 1;
      step();
      bus8.loada = 0; bus8.loadb = 0;
      bus8.ALUop = 2'b00; bus8.loadc = 1; bus8.loads = 1;
      step();
      bus8.loads = 0;
      n_checks++;
      if (bus8.C !== 8'h00) begin
         n_fail++; $display("FAIL w8_add_c: got %h expected 00", bus8.C);
      end
      n_checks++;
      if (bus8.Z_out !== 3'b101) begin
         n_fail++; $display("FAIL w8_add_z: got %b expected 101", bus8.Z_out);
      end
      bus8.asel = 1; bus8.shift = 2'b11;
      step();
      n_checks++;
      if (bus8.C !== 8'hC0) begin
         n_fail++; $display("FAIL w8_asr_c: got %h expected c0", bus8.C);
      end
      idle8();
   endtask

   task automatic test_bypass();
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      idle16();
      wr16(6, 16'h0033);
      bus16.write = 1; bus16.writenum = 6; bus16.vsel = 2'b11; bus16.mdata = 16'h00AA;
      bus16.readnum_a = 6; bus16.loada = 1;
      step();
      bus16.loada = 0;
      exp_a = BYPASS ? 16'h00AA : 16'h0033;
      n_checks++;
      if (dut16.reg_a !== exp_a) begin
         n_fail++; $display("FAIL bypass_a: got %h expected %h", dut16.reg_a, exp_a);
      end
      n_checks++;
      if (dut16.regs[6] !== 16'h00AA) begin
         n_fail++; $display("FAIL bypass_r6: got %h expected 00aa", dut16.regs[6]);
      end
      bus16.mdata = 16'h005C; bus16.readnum_b = 6; bus16.loadb = 1;
      step();
      bus16.write = 0; bus16.loadb = 0;
      exp_b = BYPASS ? 16'h005C : 16'h00AA;
      n_checks++;
      if (dut16.reg_b !== exp_b) begin
         n_fail++; $display("FAIL bypass_b: got %h expected %h", dut16.reg_b, exp_b);
      end
      idle16();
   endtask

   // ------------------------------------------------------------------------
   // Randomized traffic against an arithmetic model of the 16-bit datapath
   // ------------------------------------------------------------------------
   function automatic int to_signed16(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic int sext(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v + 65536 - (1 << bits) : v;
   endfunction

   task automatic test_random();
      int m_regs [8];
      int m_a, m_b, m_c, m_z;
      int din, rda, rdb, sb, ain, bin, res, sres, ov;
      idle16();
      rst = 1; step(); rst = 0; step();
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_a = 0; m_b = 0; m_c = 0; m_z = 0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         bus16.readnum_a = 3'($urandom_range(0, 7));
         bus16.readnum_b = 3'($urandom_range(0, 7));
         bus16.writenum  = 3'($urandom_range(0, 7));
         bus16.write     = 1'($urandom_range(0, 1));
         bus16.vsel      = 2'($urandom_range(0, 3));
         bus16.loada     = 1'($urandom_range(0, 1));
         bus16.loadb     = 1'($urandom_range(0, 1));
         bus16.asel      = ($urandom_range(0, 3) == 0);
         bus16.bsel      = ($urandom_range(0, 3) == 0);
         bus16.shift     = 2'($urandom_range(0, 3));
         bus16.ALUop     = 2'($urandom_range(0, 3));
         bus16.loadc     = 1'($urandom_range(0, 1));
         bus16.loads     = 1'($urandom_range(0, 1));
         bus16.sximm8    = 16'(sext($urandom_range(0, 255), 8));
         bus16.sximm5    = 16'(sext($urandom_range(0, 31), 5));
         bus16.mdata     = 16'($urandom_range(0, 65535));
         bus16.PC        = 8'($urandom_range(0, 255));

         case (bus16.vsel)
            2'b00:   din = m_c;
            2'b01:   din = int'(bus16.PC);
            2'b10:   din = int'(bus16.sximm8);
            default: din = int'(bus16.mdata);
         endcase

         rda = m_regs[bus16.readnum_a];
         rdb = m_regs[bus16.readnum_b];
         if (BYPASS && bus16.write && bus16.writenum == bus16.readnum_a) rda = din;
         if (BYPASS && bus16.write && bus16.writenum == bus16.readnum_b) rdb = din;

         case (bus16.shift)
            2'b00:   sb = m_b;
            2'b01:   sb = (m_b * 2) % 65536;
            2'b10:   sb = m_b / 2;
            default: sb = m_b / 2 + ((m_b >= 32768) ? 32768 : 0);
         endcase
         ain = bus16.asel ? 0 : m_a;
         bin = bus16.bsel ? int'(bus16.sximm5) : sb;

         ov = 0;
         case (bus16.ALUop)
            2'b00: begin
               res  = (ain + bin) % 65536;
               sres = to_signed16(ain) + to_signed16(bin);
               ov   = (sres > 32767 || sres < -32768) ? 1 : 0;
            end
            2'b01: begin
               res  = (ain - bin + 65536) % 65536;
               sres = to_signed16(ain) - to_signed16(bin);
               ov   = (sres > 32767 || sres < -32768) ? 1 : 0;
            end
            2'b10:   res = ain & bin;
            default: res = 65535 - bin;
         endcase

         #1;
         n_checks++;
         if (dut16.data_in !== 16'(din)) begin
            n_fail++;
            $display("FAIL rand_din cyc %0d: got %h expected %h", cyc, dut16.data_in, 16'(din));
         end

         step();

         if (bus16.write) m_regs[bus16.writenum] = din;
         if (bus16.loada) m_a = rda;
         if (bus16.loadb) m_b = rdb;
         if (bus16.loadc) m_c = res;
         if (bus16.loads) m_z = ((res == 0) ? 4 : 0) + ((res >= 32768) ? 2 : 0) + ov;

         n_checks++;
         if (bus16.C !== 16'(m_c)) begin
            n_fail++;
            $display("FAIL rand_c cyc %0d: got %h expected %h", cyc, bus16.C, 16'(m_c));
         end
         n_checks++;
         if (bus16.Z_out !== 3'(m_z)) begin
            n_fail++;
            $display("FAIL rand_z cyc %0d: got %b expected %b", cyc, bus16.Z_out, 3'(m_z));
         end
      end

      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (dut16.regs[i] !== 16'(m_regs[i])) begin
            n_fail++;
            $display("FAIL rand_r%0d: got %h expected %h", i, dut16.regs[i], 16'(m_regs[i]));
         end
      end
      idle16();
   endtask

   // ------------------------------------------------------------------------
   // Sequence
   // ------------------------------------------------------------------------
   initial begin
      rst = 1;
      idle16();
      idle8();
      test_reset();
      test_sub();
      test_shift_add();
      test_flags();
      test_vsel_and_reset();
      test_w8();
      test_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
